// File: rtl/calc2_port_sched.sv
// calc2_port_sched: shares one calc2 request port among NUM_CLIENTS requesters.
// Round-robin grant, lowest-free tag allocation out of 4, two-cycle request
// beats (OP1: cmd/op1, OP2: op2), response routed back to the tag owner.
// Optional feature macro: CALC2_SCHED_TIMEOUT_EN adds per-tag response timeouts
// that strobe the owner with resp=2'b11, data=0 after TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | port outputs zero; accept a command if a client is valid and a tag is free
// OP1   | driving cmd, op1 and tag
// OP2   | driving cmd=0, op2 and tag
module calc2_port_sched #(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      c_clk,
    input  logic                      reset,
    input  logic [NUM_CLIENTS-1:0]    cli_req_valid,
    output logic [NUM_CLIENTS-1:0]    cli_req_ready,
    input  logic [4*NUM_CLIENTS-1:0]  cli_req_cmd,
    input  logic [32*NUM_CLIENTS-1:0] cli_req_op1,
    input  logic [32*NUM_CLIENTS-1:0] cli_req_op2,
    output logic [NUM_CLIENTS-1:0]    cli_rsp_valid,
    output logic [1:0]                cli_rsp_resp,
    output logic [31:0]               cli_rsp_data,
    output logic [3:0]                req_cmd_in,
    output logic [31:0]               req_data_in,
    output logic [1:0]                req_tag_in,
    input  logic [1:0]                out_resp,
    input  logic [31:0]               out_data,
    input  logic [1:0]                out_tag,
    output logic [2:0]                tags_free,
    output logic                      err_spurious
);

    localparam int CW = $clog2(NUM_CLIENTS);

    if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("calc2_port_sched: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, OP1, OP2} state_t;

    state_t        state, state_next;
    logic [3:0]    busy, busy_next;
    logic [CW-1:0] owner [4];
    logic [CW-1:0] rr_ptr;
    logic [31:0]   op2_hold;

    logic          grant_found;
    logic [CW-1:0] grant_idx;
    logic          tag_found;
    logic [1:0]    alloc_tag;
    logic          accept;
    logic [3:0]    cmd_next;
    logic [31:0]   data_next;
    logic [1:0]    tag_next;

    logic          rsp_hit, rsp_spur, rsp_fire;
    logic [1:0]    rsp_tag, rsp_code;
    logic [31:0]   rsp_word;

    // Round-robin search: first valid client at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        logic [CW-1:0] idx_c;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_c       = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
            idx_c = CW'(idx);
            if (!grant_found && cli_req_valid[idx_c]) begin
                grant_found = 1'b1;
                grant_idx   = idx_c;
            end
        end
    end

    // Lowest-numbered free tag from the mask at the start of the cycle.
    always_comb begin
        tag_found = 1'b0;
        alloc_tag = 2'd0;
        for (int t = 3; t >= 0; t--) begin
            if (!busy[t]) begin
                tag_found = 1'b1;
                alloc_tag = 2'(t);
            end
        end
    end

    // Free-tag population count.
    always_comb begin
        tags_free = 3'd0;
        for (int t = 0; t < 4; t++) tags_free = tags_free + {2'b00, ~busy[t]};
    end

    assign rsp_hit  = (out_resp != 2'b00) &&  busy[out_tag];
    assign rsp_spur = (out_resp != 2'b00) && !busy[out_tag];

`ifdef CALC2_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] AGE_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] age [4];
    logic          tmo_found;
    logic [1:0]    tmo_tag;

    // Lowest busy tag whose age counter has reached the limit.
    always_comb begin
        tmo_found = 1'b0;
        tmo_tag   = 2'd0;
        for (int t = 3; t >= 0; t--) begin
            if (busy[t] && age[t] == AGE_LAST) begin
                tmo_found = 1'b1;
                tmo_tag   = 2'(t);
            end
        end
    end

    // Per-tag age; saturates at the limit so a timeout deferred by a real response retries.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < 4; t++) age[t] <= '0;
        end else begin
            for (int t = 0; t < 4; t++) begin
                if (accept && alloc_tag == 2'(t)) age[t] <= '0;
                else if (busy[t] && age[t] != AGE_LAST) age[t] <= age[t] + 1'b1;
            end
        end
    end
`endif

    // Pick the response to strobe this cycle: a real response always wins.
    always_comb begin
        rsp_fire = rsp_hit;
        rsp_tag  = out_tag;
        rsp_code = out_resp;
        rsp_word = out_data;
`ifdef CALC2_SCHED_TIMEOUT_EN
        if (!rsp_hit && tmo_found) begin
            rsp_fire = 1'b1;
            rsp_tag  = tmo_tag;
            rsp_code = 2'b11;
            rsp_word = 32'd0;
        end
`endif
    end

    // Next state, accept handshake and next values of the registered port outputs.
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        cli_req_ready = '0;
        cmd_next      = 4'd0;
        data_next     = 32'd0;
        tag_next      = 2'd0;
        case (state)
            IDLE: begin
                // Ready stays low while reset is held so no transfer is lost.
                if (grant_found && tag_found && !reset) begin
                    accept        = 1'b1;
                    cli_req_ready = NUM_CLIENTS'(1) << grant_idx;
                    cmd_next      = cli_req_cmd[4*grant_idx +: 4];
                    data_next     = cli_req_op1[32*grant_idx +: 32];
                    tag_next      = alloc_tag;
                    state_next    = OP1;
                end
            end
            OP1: begin
                data_next  = op2_hold;
                tag_next   = req_tag_in;
                state_next = OP2;
            end
            default: state_next = IDLE;
        endcase
    end

    // Busy mask: release the responding tag, claim the allocated one.
    always_comb begin
        busy_next = busy;
        if (rsp_fire) busy_next[rsp_tag] = 1'b0;
        if (accept)   busy_next[alloc_tag] = 1'b1;
    end

    // FSM state, port outputs, RR pointer and held op2.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_cmd_in  <= 4'd0;
            req_data_in <= 32'd0;
            req_tag_in  <= 2'd0;
            rr_ptr      <= '0;
            op2_hold    <= 32'd0;
        end else begin
            state       <= state_next;
            req_cmd_in  <= cmd_next;
            req_data_in <= data_next;
            req_tag_in  <= tag_next;
            if (accept) begin
                op2_hold <= cli_req_op2[32*grant_idx +: 32];
                rr_ptr   <= (grant_idx == CW'(NUM_CLIENTS - 1)) ? '0 : grant_idx + CW'(1);
            end
        end
    end

    // Tag ownership, response strobe and sticky spurious flag.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            busy          <= 4'd0;
            for (int t = 0; t < 4; t++) owner[t] <= '0;
            cli_rsp_valid <= '0;
            cli_rsp_resp  <= 2'd0;
            cli_rsp_data  <= 32'd0;
            err_spurious  <= 1'b0;
        end else begin
            busy          <= busy_next;
            if (accept) owner[alloc_tag] <= grant_idx;
            cli_rsp_valid <= rsp_fire ? (NUM_CLIENTS'(1) << owner[rsp_tag]) : '0;
            cli_rsp_resp  <= rsp_fire ? rsp_code : 2'd0;
            cli_rsp_data  <= rsp_fire ? rsp_word : 32'd0;
            if (rsp_spur) err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_calc2_port_sched.sv
// Bench for calc2_port_sched: random clients and a behavioural calc2 responder.
// Expected request beats and response strobes are queued by the stimulus side
// and consumed by two independent monitors.
`timescale 1ns/1ps
module tb_calc2_port_sched;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic            c_clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    cli_req_valid, cli_req_ready, cli_rsp_valid;
    logic [4*N-1:0]  cli_req_cmd;
    logic [32*N-1:0] cli_req_op1, cli_req_op2;
    logic [1:0]      cli_rsp_resp;
    logic [31:0]     cli_rsp_data;
    logic [3:0]      req_cmd_in;
    logic [31:0]     req_data_in;
    logic [1:0]      req_tag_in;
    logic [1:0]      out_resp, out_tag;
    logic [31:0]     out_data;
    logic [2:0]      tags_free;
    logic            err_spurious;

    calc2_port_sched #(.NUM_CLIENTS(N), .TIMEOUT_CYCLES(TMO)) dut (
        .c_clk(c_clk), .reset(reset),
        .cli_req_valid(cli_req_valid), .cli_req_ready(cli_req_ready),
        .cli_req_cmd(cli_req_cmd), .cli_req_op1(cli_req_op1), .cli_req_op2(cli_req_op2),
        .cli_rsp_valid(cli_rsp_valid), .cli_rsp_resp(cli_rsp_resp), .cli_rsp_data(cli_rsp_data),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .tags_free(tags_free), .err_spurious(err_spurious)
    );

    always #5 c_clk = ~c_clk;

    typedef struct { logic [3:0] cmd; logic [31:0] op1; logic [31:0] op2; logic [1:0] tag; } req_t;
    typedef struct { int client; logic [1:0] resp; logic [31:0] data; } rsp_t;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: abstract scheduler state.
    int          m_rr;
    bit          m_busy [4];
    int          m_owner[4];
    int          m_alloc[4];
    int          m_lock;
    bit          m_err;
    int          cyc;

    // Client-side driver state.
    bit          pend [N];
    logic [3:0]  d_cmd[N];
    logic [31:0] d_op1[N];
    logic [31:0] d_op2[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_lock = 0; m_err = 1'b0;
        for (int t = 0; t < 4; t++) begin m_busy[t] = 1'b0; m_owner[t] = 0; m_alloc[t] = 0; end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        exp_req_q.delete();
        exp_rsp_q.delete();
    endtask

    // One clock cycle: entered just after a rising edge, leaves just after the next one.
    task automatic step(input int p_valid, input logic [N-1:0] mask, input int p_rsp, input int p_spur);
        int          cand[$];
        int          g, t_alloc, free_cnt, idx;
        logic [N-1:0] exp_ready;
        bit          hit;
        rsp_t        rs;
        req_t        rq;

        for (int i = 0; i < N; i++) begin
            if (!pend[i] && mask[i] && $urandom_range(99) < p_valid) begin
                pend[i]  = 1'b1;
                d_cmd[i] = 4'($urandom_range(15, 1));
                d_op1[i] = $urandom;
                d_op2[i] = $urandom;
            end else if (!pend[i]) begin
                d_cmd[i] = 4'($urandom);
                d_op1[i] = $urandom;
                d_op2[i] = $urandom;
            end
            cli_req_valid[i]          = pend[i];
            cli_req_cmd[4*i +: 4]     = d_cmd[i];
            cli_req_op1[32*i +: 32]   = d_op1[i];
            cli_req_op2[32*i +: 32]   = d_op2[i];
        end

        out_resp = 2'd0; out_tag = 2'd0; out_data = 32'd0;
        for (int t = 0; t < 4; t++) if (m_busy[t] && cyc - m_alloc[t] >= 3) cand.push_back(t);
        if (cand.size() > 0 && $urandom_range(99) < p_rsp) begin
            out_tag  = 2'(cand[$urandom_range(cand.size() - 1)]);
            out_resp = 2'($urandom_range(3, 1));
            out_data = $urandom;
        end else if ($urandom_range(99) < p_spur) begin
            cand.delete();
            for (int t = 0; t < 4; t++) if (!m_busy[t]) cand.push_back(t);
            if (cand.size() > 0) begin
                out_tag  = 2'(cand[$urandom_range(cand.size() - 1)]);
                out_resp = 2'($urandom_range(3, 1));
                out_data = $urandom;
            end
        end

        @(negedge c_clk);
        free_cnt = 0; t_alloc = -1;
        for (int t = 0; t < 4; t++) if (!m_busy[t]) begin
            free_cnt++;
            if (t_alloc < 0) t_alloc = t;
        end
        g = -1;
        if (m_lock == 0 && free_cnt > 0)
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && pend[idx]) g = idx;
            end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("cli_req_ready", 64'(cli_req_ready), 64'(exp_ready));
        chk("tags_free", 64'(tags_free), 64'(free_cnt));
        chk("err_spurious", 64'(err_spurious), 64'(m_err));

        hit = (out_resp != 2'd0) && m_busy[out_tag];
        if (hit) begin
            rs.client = m_owner[out_tag]; rs.resp = out_resp; rs.data = out_data;
            exp_rsp_q.push_back(rs);
            m_busy[out_tag] = 1'b0;
        end else begin
            if (out_resp != 2'd0) m_err = 1'b1;
`ifdef CALC2_SCHED_TIMEOUT_EN
            for (int t = 0; t < 4; t++) begin
                if (!hit && m_busy[t] && cyc - m_alloc[t] >= TMO) begin
                    rs.client = m_owner[t]; rs.resp = 2'b11; rs.data = 32'd0;
                    exp_rsp_q.push_back(rs);
                    m_busy[t] = 1'b0;
                    hit = 1'b1;
                end
            end
`endif
        end

        if (g >= 0) begin
            rq.cmd = d_cmd[g]; rq.op1 = d_op1[g]; rq.op2 = d_op2[g]; rq.tag = 2'(t_alloc);
            exp_req_q.push_back(rq);
            m_busy[t_alloc]  = 1'b1;
            m_owner[t_alloc] = g;
            m_alloc[t_alloc] = cyc;
            m_rr   = (g + 1) % N;
            m_lock = 2;
            pend[g] = 1'b0;
        end else if (m_lock > 0) begin
            m_lock--;
        end
        cyc++;
        @(posedge c_clk);
        #1;
    endtask

    // Request-port monitor: OP1 beat recognised by a nonzero command, OP2 follows.
    initial begin : req_mon
        req_t e;
        bit   op2_due;
        op2_due = 1'b0;
        e.cmd = 4'd0; e.op1 = 32'd0; e.op2 = 32'd0; e.tag = 2'd0;
        forever begin
            @(negedge c_clk);
            if (reset) begin
                op2_due = 1'b0;
            end else if (op2_due) begin
                chk("op2_cmd", 64'(req_cmd_in), 64'd0);
                chk("op2_data", 64'(req_data_in), 64'(e.op2));
                chk("op2_tag", 64'(req_tag_in), 64'(e.tag));
                op2_due = 1'b0;
            end else if (req_cmd_in != 4'd0) begin
                if (exp_req_q.size() == 0) begin
                    chk("req_unexpected", 64'(req_cmd_in), 64'd0);
                end else begin
                    e = exp_req_q.pop_front();
                    chk("op1_cmd", 64'(req_cmd_in), 64'(e.cmd));
                    chk("op1_data", 64'(req_data_in), 64'(e.op1));
                    chk("op1_tag", 64'(req_tag_in), 64'(e.tag));
                    op2_due = 1'b1;
                end
            end else begin
                chk("req_idle", 64'({req_data_in, req_tag_in}), 64'd0);
            end
        end
    end

    // Client response monitor.
    initial begin : rsp_mon
        rsp_t e;
        forever begin
            @(negedge c_clk);
            if (cli_rsp_valid != '0) begin
                if (exp_rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(cli_rsp_valid), 64'd0);
                end else begin
                    e = exp_rsp_q.pop_front();
                    chk("rsp_valid", 64'(cli_rsp_valid), 64'(N'(1) << e.client));
                    chk("rsp_resp", 64'(cli_rsp_resp), 64'(e.resp));
                    chk("rsp_data", 64'(cli_rsp_data), 64'(e.data));
                end
            end else begin
                chk("rsp_idle", 64'({cli_rsp_resp, cli_rsp_data}), 64'd0);
            end
        end
    end

    initial begin : main
        cli_req_valid = '1; cli_req_cmd = '1; cli_req_op1 = '0; cli_req_op2 = '0;
        out_resp = 2'd0; out_tag = 2'd0; out_data = 32'd0;
        cyc = 0;
        model_reset();

        repeat (3) @(posedge c_clk);
        @(negedge c_clk);
        chk("rst_ready", 64'(cli_req_ready), 64'd0);
        chk("rst_tags_free", 64'(tags_free), 64'd4);
        chk("rst_req", 64'({req_cmd_in, req_data_in, req_tag_in}), 64'd0);
        chk("rst_err", 64'(err_spurious), 64'd0);
        cli_req_valid = '0;
        @(posedge c_clk);
        #1;
        reset = 1'b0;

        // Burst: all clients at once, no responses -> tags exhausted, ready held low.
        repeat (16) step(100, '1, 0, 0);
        // Mixed random traffic with out-of-order responses.
        repeat (1500) step(40, '1, 35, 0);
        // Occasional spurious responses.
        repeat (200) step(40, '1, 35, 5);
        // Drain.
        repeat (40) step(0, '0, 100, 0);
        chk("drain_free", 64'(tags_free), 64'd4);

        // One tag left outstanding for a long time.
        step(100, N'(1), 0, 0);
        repeat (80) step(0, '0, 0, 0);
        repeat (20) step(0, '0, 100, 0);

        // Reset while a command is in OP2.
        step(100, N'(4), 0, 0);
        step(0, '0, 0, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", 64'({req_cmd_in, req_data_in, req_tag_in}), 64'd0);
        chk("mid_rst_free", 64'(tags_free), 64'd4);
        model_reset();
        cli_req_valid = '0;
        @(posedge c_clk);
        #1;
        reset = 1'b0;
        step(0, '0, 0, 100);
        step(100, '1, 0, 0);
        repeat (300) step(50, '1, 40, 0);
        repeat (40) step(0, '0, 100, 0);
        repeat (2) @(negedge c_clk);

        chk("req_left", 64'(exp_req_q.size()), 64'd0);
        chk("rsp_left", 64'(exp_rsp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
